// File: rtl/mem_byte_responder.sv
// mem_byte_responder: memory-side responder for a byte-masked 16-bit memory interface.
// Holds a word-organised storage array; every read or write request is acknowledged with a
// one-cycle mem_resp exactly LATENCY cycles after the request is sampled in IDLE.
//
// Ports:
//   clk             - single clock, rising edge
//   reset           - asynchronous, active-high
//   mem_read        - read request, held until mem_resp
//   mem_write       - write request, held until mem_resp (wins over mem_read)
//   mem_address     - byte address; word index is mem_address[ADDR_BITS:1]
//   mem_wdata       - write data
//   mem_byte_enable - bit1 enables [15:8], bit0 enables [7:0] (writes only)
//   mem_rdata       - read data, updated only when a read enters RESP
//   mem_resp        - one-cycle completion pulse
module mem_byte_responder #(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_rdata,
  output logic        mem_resp
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]           r_state;
  logic [3:0]           r_count;
  logic [ADDR_BITS-1:0] r_addr;
  logic [15:0]          r_wdata;
  logic [1:0]           r_mask;
  logic                 r_is_write;
  logic [15:0]          r_rdata;
  logic [15:0]          r_mem [2**ADDR_BITS];

  logic [1:0]           w_state_d;
  logic [3:0]           w_count_d;
  logic                 w_capture;
  logic                 w_enter_resp;
  logic                 w_cur_write;
  logic [ADDR_BITS-1:0] w_cur_addr;
  logic [15:0]          w_cur_wdata;
  logic [1:0]           w_cur_mask;

  // Address bit 0 and bits above the array size are deliberately ignored (aliasing).
  logic w_unused;
  assign w_unused = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_write || mem_read) begin
          w_capture = 1'b1;
          if (LATENCY == 1) begin
            w_state_d = ST_RESP;
          end else begin
            w_state_d = ST_WAIT;
            w_count_d = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        // Leaving WAIT on the edge where the counter decrements to zero puts RESP in cycle
        // LATENCY counted from the IDLE sampling cycle.
        if (r_count <= 4'd1) begin
          w_state_d = ST_RESP;
          w_count_d = 4'd0;
        end else begin
          w_count_d = r_count - 4'd1;
        end
      end
      ST_RESP: w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  assign w_enter_resp = (w_state_d == ST_RESP) && (r_state != ST_RESP);

  // With LATENCY=1 the capture and commit happen on the same edge, so the live inputs are used.
  assign w_cur_write = (r_state == ST_IDLE) ? mem_write                     : r_is_write;
  assign w_cur_addr  = (r_state == ST_IDLE) ? mem_address[ADDR_BITS:1]      : r_addr;
  assign w_cur_wdata = (r_state == ST_IDLE) ? mem_wdata                     : r_wdata;
  assign w_cur_mask  = (r_state == ST_IDLE) ? mem_byte_enable               : r_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= 16'h0000;
      r_mask     <= 2'b00;
      r_is_write <= 1'b0;
      r_rdata    <= 16'h0000;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      if (w_capture) begin
        r_addr     <= mem_address[ADDR_BITS:1];
        r_wdata    <= mem_wdata;
        r_mask     <= mem_byte_enable;
        r_is_write <= mem_write;
      end
      if (w_enter_resp && !w_cur_write) begin
        r_rdata <= r_mem[w_cur_addr];
      end
    end
  end

  // Storage is never cleared; a reset during the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_cur_write && !reset) begin
      if (w_cur_mask[1]) r_mem[w_cur_addr][15:8] <= w_cur_wdata[15:8];
      if (w_cur_mask[0]) r_mem[w_cur_addr][7:0]  <= w_cur_wdata[7:0];
    end
  end

  assign mem_rdata = r_rdata;
  assign mem_resp  = (r_state == ST_RESP);

endmodule

// File: tb/tb_mem_byte_responder.sv
module tb_mem_byte_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  // Latency-sweep instances share one held read request.
  logic        lat_read;
  logic [2:0]  lat_resp;
  logic [15:0] lat_rdata [3];

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        is_read;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_rdata;

  always #5 clk = ~clk;

  mem_byte_responder #(.LATENCY(LAT), .ADDR_BITS(8)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  mem_byte_responder #(.LATENCY(1), .ADDR_BITS(8)) u_lat1 (
    .clk             (clk),
    .reset           (reset),
    .mem_read        (lat_read),
    .mem_write       (1'b0),
    .mem_address     (16'h0000),
    .mem_wdata       (16'h0000),
    .mem_byte_enable (2'b11),
    .mem_rdata       (lat_rdata[0]),
    .mem_resp        (lat_resp[0])
  );

  mem_byte_responder #(.LATENCY(2), .ADDR_BITS(8)) u_lat2 (
    .clk             (clk),
    .reset           (reset),
    .mem_read        (lat_read),
    .mem_write       (1'b0),
    .mem_address     (16'h0000),
    .mem_wdata       (16'h0000),
    .mem_byte_enable (2'b11),
    .mem_rdata       (lat_rdata[1]),
    .mem_resp        (lat_resp[1])
  );

  mem_byte_responder #(.LATENCY(7), .ADDR_BITS(8)) u_lat7 (
    .clk             (clk),
    .reset           (reset),
    .mem_read        (lat_read),
    .mem_write       (1'b0),
    .mem_address     (16'h0000),
    .mem_wdata       (16'h0000),
    .mem_byte_enable (2'b11),
    .mem_rdata       (lat_rdata[2]),
    .mem_resp        (lat_resp[2])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pops one expectation per resp pulse.
  always @(negedge clk) begin
    if (!reset && mem_resp) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.is_read) begin
          check("read_data", {16'h0, mem_rdata}, {16'h0, e.data});
          model_rdata = e.data;
        end else begin
          check("rdata_kept_on_write", {16'h0, mem_rdata}, {16'h0, model_rdata});
        end
      end
    end
  end

  // Issues one request in an IDLE cycle and checks the resp cycle and pulse width.
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [1:0] be, input logic [15:0] exp);
    int  n;
    bit  got;
    exp_t e;
    e.is_read = rd && !wr;
    e.data    = exp;
    sb_q.push_back(e);
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_wdata       = wd;
    mem_byte_enable = be;
    n   = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (mem_resp) got = 1;
    end
    check("resp_latency", n, LAT);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    check("resp_one_pulse", {31'h0, mem_resp}, 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = 16'h0000;
    mem_wdata       = 16'h0000;
    mem_byte_enable = 2'b00;
    lat_read        = 1'b0;
    model_rdata     = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_resp", {31'h0, mem_resp}, 32'd0);
    check("reset_rdata", {16'h0, mem_rdata}, 32'h0);
    reset = 1'b0;

    // Full word write then read.
    do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF);

    // Byte merge; odd address selects the same word.
    do_req(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 16'h0000);
    do_req(1'b0, 1'b1, 16'h0021, 16'hAB00, 2'b10, 16'h0000);
    do_req(1'b0, 1'b1, 16'h0020, 16'h00CD, 2'b01, 16'h0000);
    do_req(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11, 16'hABCD);

    // Mask 00 modifies nothing.
    do_req(1'b0, 1'b1, 16'h0030, 16'h5555, 2'b11, 16'h0000);
    do_req(1'b0, 1'b1, 16'h0030, 16'hFFFF, 2'b00, 16'h0000);
    do_req(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b11, 16'h5555);

    // Read and write together: write wins, rdata untouched.
    do_req(1'b1, 1'b1, 16'h0050, 16'h0F0F, 2'b11, 16'h0000);
    do_req(1'b1, 1'b0, 16'h0050, 16'h0000, 2'b11, 16'h0F0F);

    // Aliasing modulo 512 bytes.
    do_req(1'b0, 1'b1, 16'h0002, 16'hCAFE, 2'b11, 16'h0000);
    do_req(1'b1, 1'b0, 16'h0202, 16'h0000, 2'b11, 16'hCAFE);

    // Reset during WAIT of a write drops it.
    do_req(1'b0, 1'b1, 16'h0040, 16'h1111, 2'b11, 16'h0000);
    mem_write       = 1'b1;
    mem_address     = 16'h0040;
    mem_wdata       = 16'h7777;
    mem_byte_enable = 2'b11;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    mem_write = 1'b0;
    #1;
    model_rdata = 16'h0000;
    check("midreset_resp", {31'h0, mem_resp}, 32'd0);
    check("midreset_rdata", {16'h0, mem_rdata}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("midreset_no_resp", {31'h0, mem_resp}, 32'd0);
    end
    reset = 1'b0;
    do_req(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11, 16'h1111);

    // Latency sweep with a held read.
    begin
      int lat[3];
      int last[3];
      int npulse[3];
      int exp_pulses[3];
      lat        = '{1, 2, 7};
      exp_pulses = '{20, 13, 5};
      last       = '{-1, -1, -1};
      npulse     = '{0, 0, 0};
      lat_read   = 1'b1;
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
          if (lat_resp[k]) begin
            if (last[k] < 0) check("sweep_first_resp", c, lat[k]);
            else             check("sweep_period", c - last[k], lat[k] + 1);
            last[k] = c;
            npulse[k]++;
          end
        end
      end
      lat_read = 1'b0;
      for (int k = 0; k < 3; k++) check("sweep_pulse_count", npulse[k], exp_pulses[k]);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_byte_responder.md
# mem_byte_responder

Memory-side responder for the LC-3b byte-masked memory interface. It accepts read and write requests from the datapath/cache initiator and holds a word-organised storage array. Writes are committed per byte under `mem_byte_enable`, and every access is acknowledged with a one-cycle `mem_resp` after a fixed, parameterised latency. It sits behind the CPU's byte-select logic and serves as the physical-memory model and the synthesizable scratch memory.

## Interface
- `LATENCY`, default 2: cycles from request sampling to `mem_resp`. Legal range 1..15.
- `ADDR_BITS`, default 8: log2 of the storage depth in 16-bit words.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `mem_read` input, 1 bit: read request, held until `mem_resp`.
- `mem_write` input, 1 bit: write request, held until `mem_resp`.
- `mem_address` input, 16 bits (`lc3b_word`): byte address.
- `mem_wdata` input, 16 bits (`lc3b_word`): write data.
- `mem_byte_enable` input, 2 bits (`lc3b_mem_wmask`): bit1 enables [15:8], bit0 enables [7:0].
- `mem_rdata` output, 16 bits (`lc3b_word`): read data, valid while `mem_resp` is high after a read.
- `mem_resp` output, 1 bit: one-cycle completion pulse.

## Operation
- Word index is `mem_address[ADDR_BITS:1]`.
  - `mem_address[0]` is ignored; byte steering is done by the initiator.
  - Upper address bits are ignored, so addresses alias modulo 2^(ADDR_BITS+1) bytes.
- States are IDLE, WAIT and RESP.
- **IDLE**
  - If `mem_write` is high, capture address, wdata, mask and op=write.
  - Otherwise, if `mem_read` is high, capture address and op=read.
  - If both are high, the write wins and no read is performed.
  - On capture, go to WAIT with counter=LATENCY-1. If LATENCY=1, go straight to RESP.
- **WAIT**
  - Decrement the counter each cycle. When it reaches 0 in WAIT (checked on the edge leaving WAIT), go to RESP.
  - Request inputs are ignored; captured values are used.
- **Entering RESP** (single edge)
  - A write commits the enabled bytes of the captured wdata to the array:
    - mask 11 writes the whole word.
    - mask 10 writes [15:8] only.
    - mask 01 writes [7:0] only.
    - mask 00 modifies nothing but still responds.
  - A read loads `mem_rdata` with the full array word. The mask is ignored for reads.
- **RESP**
  - `mem_resp`=1 for exactly this cycle. Inputs are ignored.
  - Next state is IDLE unconditionally.
- `mem_rdata` holds its last read value outside RESP. Writes never change `mem_rdata`.
- Array contents are not cleared by reset and are X until written.

## Timing
- Reset values: state=IDLE, counter=0, `mem_resp`=0, `mem_rdata`=16'h0000.
- A request visible in IDLE during cycle 0 produces `mem_resp` high in cycle LATENCY.
- Throughput is one access per LATENCY+1 cycles.
  - A request still asserted in the RESP cycle is not sampled.
  - If it is still asserted in the following IDLE cycle, it is a new request.
- Read-after-write: a read issued in the IDLE cycle after a write's RESP returns the merged word.
- Reset asserted mid-operation (WAIT or RESP):
  - Immediately forces IDLE and `mem_resp`=0.
  - A pending write is dropped and the array is untouched, unless the commit edge already occurred.
  - After reset deasserts, the first sampled request starts a fresh latency count.
- A request that drops in WAIT before `mem_resp` is still completed; the initiator is non-compliant.

## Test plan
- Full-word write, then read (LATENCY=2):
  - Write 16'hBEEF, mask 11, address 16'h0010 → `mem_resp` high in cycle 2 only.
  - Read of 16'h0010 → `mem_rdata`=16'hBEEF in its resp cycle.
- Byte merge:
  - Write 16'h1234 (mask 11) to 16'h0020.
  - Write 16'hAB00 (mask 10) to 16'h0021.
  - Write 16'h00CD (mask 01) to 16'h0020.
  - Read 16'h0020 → 16'hABCD.
- Mask 00 and both requests high:
  - Write mask 00 of 16'hFFFF over 16'h5555 → read returns 16'h5555, resp still one pulse.
  - `mem_read`=`mem_write`=1 with wdata 16'h0F0F, mask 11 → treated as a write; `mem_rdata` unchanged.
- Latency sweep LATENCY=1,2,7: request seen in cycle 0 → `mem_resp` in exactly cycle LATENCY. Held request yields a new resp every LATENCY+1 cycles.
- Reset mid-write:
  - Assert `reset` in WAIT of a 16'h7777 write over 16'h1111 → `mem_resp` never pulses; a later read returns 16'h1111.
  - `mem_rdata`=0 directly after reset.
- Aliasing (ADDR_BITS=8): write 16'hCAFE to 16'h0002, read 16'h0202 → 16'hCAFE.
